seq_mul64: RTL
==============

# seq_mul64

Iterative 64×64 unsigned shift-add multiplier for the EX stage of the 5-stage pipeline. It drives operands into one `Big_adder64` instance each cycle and consumes its `{cout, sum}` result. It produces the full 128-bit product: `lo` for MUL and `hi` for UMULH. The pipeline control holds the EX stage while `busy` is high and latches the product on `done`.

## Interface
- Parameters: none. Width is fixed at 64 by `Big_adder64`.
- `clk` in 1 — sole clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — request a multiply; sampled only in IDLE and DONE.
- `abort` in 1 — synchronous pipeline flush; cancels any operation.
- `a` in 64 — multiplicand; captured on an accepted start.
- `b` in 64 — multiplier; captured on an accepted start.
- `busy` out 1 — high in RUN.
- `done` out 1 — one-cycle pulse when the product is valid.
- `prod_lo` out 64 — product bits [63:0]; held until the next accepted start.
- `prod_hi` out 64 — product bits [127:64]; held likewise.

## Operation
- Registers:
  - `mcand[63:0]`
  - `hi[63:0]`
  - `lo[63:0]`
  - `cnt[5:0]`
  - `state`
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start=1` and `abort=0`:
  - `mcand<=a`, `lo<=b`, `hi<=0`, `cnt<=0`, `state<=RUN`.
- RUN, each cycle:
  - Adder inputs: `a=hi`, `b = lo[0] ? mcand : 64'b0`, `cin=0`.
  - Update: `{hi,lo} <= {cout, sum, lo[63:1]}` (65-bit sum shifted right by 1).
  - `cnt <= cnt+1`.
  - When `cnt==63` this cycle, `state<=DONE`.
- DONE: `done=1` for exactly this cycle.
  - Next state is RUN if a new start is accepted, otherwise IDLE.
- `prod_hi/prod_lo` are direct views of `hi/lo`. They are only architecturally valid when `done=1` and afterwards, until the next accepted start.
- `abort=1` in any state: `state<=IDLE` next edge and no `done` is produced. `hi/lo` may hold partial values.
- `start` while in RUN is ignored. There is no queueing.
- `start` and `abort` together: abort wins and the start is dropped.
- Reset, including mid-RUN:
  - `state=IDLE`, `busy=0`, `done=0`, `prod_lo=0`, `prod_hi=0`, `cnt=0`, `mcand=0`.
- Arithmetic: unsigned only. The product is exact modulo 2^128 and overflow is impossible. The adder's `cin_msb` is unused.
- Signed MUL: the low 64 bits equal the unsigned result, so `prod_lo` is correct for signed MUL as-is. Signed high-half (SMULH) is out of scope.

## Timing
- Start accepted at edge k → RUN during cycles k..k+63 → `done=1` in cycle k+64, i.e. 65 cycles start-to-done.
- Back-to-back operation: a start during the DONE cycle makes the next `done` occur 65 cycles later. No idle bubble is required.
- `busy` falls the same edge `done` rises.
- Critical path is the `Big_adder64` ripple: 64 stages × 2 gates × 50 ps ≈ 6.4 ns, plus the operand mux. The bench clock period must be ≥ 10 ns.
- All outputs are registered or decoded from `state` only. There is no combinational path from `start`, `a` or `b` to any output.

## Structure
- Package `mul_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t`
  - `localparam int MUL_ITERS = 64`
  - `localparam int MUL_CNT_W = 6`
- Sub-module: one existing `Big_adder64` instance with `cin=1'b0`. Its `cout` feeds the shift; `cin_msb` is left unconnected.
- One `always_ff` block (async `rst_n`) for state and datapath. One `always_comb` block for next state and operand select.

## Test plan
- Reset mid-RUN:
  - Stimulus: start a=5, b=7; pulse `rst_n` low at cycle 20.
  - Required: `busy=0`, `done=0`, products 0 immediately; no `done` ever appears.
- Basic multiply:
  - Stimulus: a=6, b=7.
  - Required: `done` at cycle 65 with `prod_lo=42`, `prod_hi=0`; `busy` high for exactly 64 cycles.
- Full-width carry:
  - Stimulus: a=b=64'hFFFF_FFFF_FFFF_FFFF.
  - Required: `prod_hi=64'hFFFF_FFFF_FFFF_FFFE`, `prod_lo=64'h1`.
- Back-to-back, with an ignored start:
  - Stimulus: start (2^32, 2^32), then start (3, 64'h8000_0000_0000_0000) in the DONE cycle.
  - Required: first result hi=1, lo=0; second `done` 65 cycles later with hi=1, lo=64'h8000_0000_0000_0000.
  - Also: a start pulsed during RUN has no effect.
- Abort and collision:
  - Stimulus: `abort` at RUN cycle 30; then `start` and `abort` high together in IDLE.
  - Required: IDLE next cycle, no `done` in either case.
  - A subsequent clean start with a=0, b=123 gives `done` with both products 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 64x64 shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    localparam int MUL_ITERS = 64;
    localparam int MUL_CNT_W = 6;

endpackage

// File: rtl/Big_adder64.sv
// 64-bit adder with carry-in; reports carry-out and the carry into the MSB.
module Big_adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        cin_msb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'b0, cin};
    // The carry into bit 63 is recovered from the MSB sum bit and its operands.
    assign cin_msb     = a[63] ^ b[63] ^ sum[63];

endmodule

// File: rtl/seq_mul64.sv
// Iterative 64x64 unsigned shift-add multiplier: one partial product per cycle, 128-bit result.
module seq_mul64
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] prod_lo,
    output logic [63:0] prod_hi
);

    mul_state_t            state, state_nxt;
    logic [63:0]           mcand, hi, lo;
    logic [MUL_CNT_W-1:0]  cnt;
    logic [63:0]           add_b, add_sum;
    logic                  add_cout;
    logic                  add_cin_msb_unused;
    logic                  accept;

    Big_adder64 u_adder (
        .a       (hi),
        .b       (add_b),
        .cin     (1'b0),
        .sum     (add_sum),
        .cout    (add_cout),
        .cin_msb (add_cin_msb_unused)
    );

    always_comb begin
        add_b     = lo[0] ? mcand : 64'b0;
        accept    = start && !abort && (state == IDLE || state == DONE);
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: state_nxt = accept ? RUN : IDLE;
                RUN:        state_nxt = (cnt == MUL_CNT_W'(MUL_ITERS - 1)) ? DONE : RUN;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand <= a;
                lo    <= b;
                hi    <= '0;
                cnt   <= '0;
            end else if (state == RUN && !abort) begin
                // The 65-bit partial sum shifts right by one into {hi, lo}.
                {hi, lo} <= {add_cout, add_sum, lo[63:1]};
                cnt      <= cnt + 1'b1;
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign prod_lo = lo;
    assign prod_hi = hi;

endmodule
